// File: rtl/pwm_config_sequencer.sv
// PWM configuration sequencer: holds a written configuration in a shadow register
// and applies it immediately (PWM off) or at the next counter boundary (PWM on).
module pwm_config_sequencer #(
  parameter int CFG_WIDTH      = 5,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 cfg_wr_valid,
  input  logic [CFG_WIDTH-1:0] cfg_wr_data,
  output logic                 cfg_wr_ready,
  input  logic                 cnt_zero,
  input  logic                 cnt_period,
  output logic                 pwm_onoff,
  output logic                 int_onoff,
  output logic                 mask_mode,
  output logic [1:0]           count_mode,
  output logic                 cnt_restart,
  output logic                 upd_done,
  output logic                 cfg_err,
  output logic                 tmo_err,
  output logic                 busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PEND  = 2'd1;
  localparam logic [1:0] APPLY = 2'd2;

  logic [1:0]           state;
  logic [CFG_WIDTH-1:0] shadow;
  logic [CFG_WIDTH-1:0] active;
  logic [TW-1:0]        tmo_cnt;
  logic                 tmo_hit;
  logic                 cfg_err_q;
  logic                 handshake;
  logic                 bad_mode;
  logic                 boundary;
  logic                 in_apply;

  // State is IDLE throughout reset, so ready alone needs explicit gating.
  assign cfg_wr_ready = rstn && (state == IDLE);
  assign handshake    = cfg_wr_valid && cfg_wr_ready;
  assign bad_mode     = (cfg_wr_data[1:0] == 2'b11);
  assign boundary     = (active[1:0] == 2'b00) ? cnt_period : cnt_zero;
  assign in_apply     = (state == APPLY);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      shadow    <= '0;
      active    <= '0;
      tmo_cnt   <= '0;
      tmo_hit   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= handshake && bad_mode;
      case (state)
        IDLE: begin
          if (handshake && !bad_mode) begin
            shadow  <= cfg_wr_data;
            tmo_cnt <= '0;
            tmo_hit <= 1'b0;
            state   <= active[4] ? PEND : APPLY;
          end
        end
        PEND: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          // A real boundary wins over a timeout landing in the same cycle.
          if (boundary) begin
            state <= APPLY;
          end else if (tmo_cnt == TMO_LAST) begin
            state   <= APPLY;
            tmo_hit <= 1'b1;
          end
        end
        APPLY: begin
          active  <= shadow;
          tmo_hit <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pwm_onoff   = active[4];
  assign int_onoff   = active[3];
  assign mask_mode   = active[2];
  assign count_mode  = active[1:0];
  assign upd_done    = in_apply;
  assign tmo_err     = in_apply && tmo_hit;
  assign cfg_err     = cfg_err_q;
  assign busy        = (state != IDLE);
  assign cnt_restart = in_apply &&
                       ((shadow[1:0] != active[1:0]) || (shadow[4] && !active[4]));

endmodule

// File: doc/pwm_config_sequencer.md
PWM_CONFIG_SEQUENCER -- requirements
Module: pwm_config_sequencer

Interface
REQ-001 The block SHALL have parameter CFG_WIDTH, default 5, meaning the configuration word width: bit4 pwm_onoff, bit3 int_onoff, bit2 mask_mode, bits1:0 count_mode.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 65535, meaning the maximum number of clocks spent waiting for a counter boundary before a forced apply.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: port clk, input, 1 bit, the single clock; port rstn, input, 1 bit, active-low reset.
REQ-004 The block SHALL have port cfg_wr_valid, input, 1 bit: a new configuration is offered.
REQ-005 The block SHALL have port cfg_wr_data, input, CFG_WIDTH bits: the offered configuration word.
REQ-006 The block SHALL have port cfg_wr_ready, output, 1 bit: the block accepts a word this cycle.
REQ-007 The block SHALL have port cnt_zero, input, 1 bit: a one-cycle pulse when the PWM counter equals 0.
REQ-008 The block SHALL have port cnt_period, input, 1 bit: a one-cycle pulse when the PWM counter equals the period value.
REQ-009 The block SHALL have ports pwm_onoff, int_onoff and mask_mode, outputs, 1 bit each: the active (applied) configuration fields.
REQ-010 The block SHALL have port count_mode, output, 2 bits: the active count mode (00 up, 01 down, 10 up-down, 11 reserved).
REQ-011 The block SHALL have port cnt_restart, output, 1 bit: a one-cycle pulse commanding the counter to reload.
REQ-012 The block SHALL have ports upd_done, cfg_err and tmo_err, outputs, 1 bit each: one-cycle pulses for apply complete, write rejected and forced apply.
REQ-013 The block SHALL have port busy, output, 1 bit: high while a configuration is pending.

Function
REQ-014 The block SHALL implement a state machine with states IDLE, PEND and APPLY.
REQ-015 The block SHALL drive cfg_wr_ready high only in IDLE.
REQ-016 A handshake SHALL occur when cfg_wr_valid and cfg_wr_ready are both high on a rising clock edge.
REQ-017 On a handshake with cfg_wr_data[1:0]=11, the block SHALL pulse cfg_err the next cycle, stay in IDLE and leave the shadow and active configuration unchanged.
REQ-018 On a valid handshake, the block SHALL latch cfg_wr_data into a shadow register.
REQ-019 On a valid handshake while active pwm_onoff=0, the block SHALL go to APPLY the next cycle with no boundary wait.
REQ-020 On a valid handshake while active pwm_onoff=1, the block SHALL go to PEND.
REQ-021 In PEND, the boundary event SHALL be selected by the active count_mode: up uses cnt_period; down and up-down use cnt_zero.
REQ-022 A boundary pulse in the same cycle as the handshake SHALL be ignored; only boundary pulses sampled while in PEND count.
REQ-023 On the first qualifying boundary in PEND, the block SHALL go to APPLY.
REQ-024 The PEND timeout counter SHALL clear on entry to PEND and increment once per PEND cycle.
REQ-025 When the timeout counter reaches TIMEOUT_CYCLES-1 with no boundary, the block SHALL go to APPLY and pulse tmo_err coincident with upd_done.
REQ-026 In APPLY (exactly one cycle), the active outputs SHALL take the shadow value at the end of the cycle.
REQ-027 In APPLY, the block SHALL pulse upd_done and return to IDLE.
REQ-028 cnt_restart SHALL pulse in the APPLY cycle if the shadow count_mode differs from the active count_mode, or if pwm_onoff transitions 0->1.
REQ-029 Write-to-active latency SHALL be 2 clocks when active pwm_onoff=0, and boundary+1 clocks otherwise.
REQ-030 busy SHALL be high in PEND and APPLY.
REQ-031 cfg_wr_valid in PEND or APPLY SHALL be ignored (ready low); the data is neither lost nor stored, and the requester holds it.

Reset
REQ-032 While rstn=0, the block SHALL set state IDLE, shadow=0, all active fields=0 and the timeout counter=0.
REQ-033 While rstn=0, the block SHALL drive cfg_wr_ready=0 and all pulses and busy=0.
REQ-034 On the first clock after rstn deasserts, cfg_wr_ready SHALL be 1.
REQ-035 Reset asserted in PEND SHALL discard the shadow with no upd_done.

Verification
REQ-036 A bench SHALL cover: after reset, write 0x12 -> active bits = 1,0,0,10 two clocks later; upd_done and cnt_restart pulse once.
REQ-037 A bench SHALL cover: active 0x10 (up), write 0x14 -> busy until cnt_period, which pulses 5 clocks later; active=0x14 on the next clock; no cnt_restart.
REQ-038 A bench SHALL cover: write 0x13 -> cfg_err pulse; active unchanged; cfg_wr_ready stays 1.
REQ-039 A bench SHALL cover: TIMEOUT_CYCLES=16, active on, no boundary -> APPLY after 16 PEND cycles; tmo_err and upd_done pulse together.
REQ-040 A bench SHALL cover: cnt_zero coincident with a handshake in down mode -> ignored; applies on the next cnt_zero.
REQ-041 A bench SHALL cover: rstn low mid-PEND -> all outputs 0 immediately; no upd_done after release.
